// File: rtl/score_board_pkg.sv
// Shared constants for the score board: BCD geometry, speed width and the
// active-low seven-segment patterns ({dp, g..a}).
package score_board_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_DIGITS = 4;
    localparam int SPEED_W    = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/score_board_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment pattern, dp always off.
module bcd_to_seg
    import score_board_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [7:0]       seg
);

    // Pattern lookup; codes above 9 blank the digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_board.sv
// Running BCD score, high score latch, scroll speed level and a multiplexed
// 4-digit seven-segment display driven from the game state and frame strobe.
module score_board
    import score_board_pkg::*;
#(
    parameter int                 FRAMES_PER_POINT = 6,
    parameter logic [SPEED_W-1:0] SPEED_BASE       = 4'd2,
    parameter logic [SPEED_W-1:0] SPEED_MAX        = 4'd9,
    parameter int                 SCAN_BITS        = 18
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                fresh,
    input  logic                game_status,
    input  logic                show_high,
    output logic [15:0]         score_bcd,
    output logic [15:0]         high_bcd,
    output logic [SPEED_W-1:0]  speed,
    output logic [3:0]          seg_an,
    output logic [7:0]          seg_cat
);

    localparam int SCORE_W = BCD_W * BCD_DIGITS;
    localparam int FC_W    = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam logic [FC_W-1:0]    FC_LAST   = FC_W'(FRAMES_PER_POINT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    logic                 fresh_prev_r, gs_prev_r;
    logic                 frame_tick_s, start_s, stop_s;
    logic [FC_W-1:0]      fc_r;
    logic [SCORE_W-1:0]   score_r, high_r, score_inc_s, src_s;
    logic                 carry_s;
    logic [4:0]           level_s, speed_sum_s;
    logic [SPEED_W-1:0]   speed_r, speed_next_s;
    logic [SCAN_BITS-1:0] scan_r;
    logic [1:0]           sel_s;
    logic [BCD_W-1:0]     digit_s;
    logic [3:0]           seg_an_r;
    logic [7:0]           seg_cat_r, cat_s;

    // Edge detection against the registered previous input values.
    always_comb begin
        frame_tick_s = fresh_prev_r & ~fresh;
        start_s      = ~gs_prev_r & game_status;
        stop_s       = gs_prev_r & ~game_status;
    end

    // BCD +1 with a per-digit 9->0 carry chain.
    always_comb begin
        score_inc_s = score_r;
        carry_s     = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry_s && (score_r[BCD_W*i +: BCD_W] == 4'd9)) begin
                score_inc_s[BCD_W*i +: BCD_W] = 4'd0;
            end else if (carry_s) begin
                score_inc_s[BCD_W*i +: BCD_W] = score_r[BCD_W*i +: BCD_W] + 4'd1;
                carry_s = 1'b0;
            end else begin
                score_inc_s[BCD_W*i +: BCD_W] = score_r[BCD_W*i +: BCD_W];
            end
        end
    end

    // Score, frame counter and high score; a start wins over a same-cycle tick.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fresh_prev_r <= fresh;
            gs_prev_r    <= game_status;
            fc_r         <= '0;
            score_r      <= '0;
            high_r       <= '0;
        end else begin
            fresh_prev_r <= fresh;
            gs_prev_r    <= game_status;
            if (start_s) begin
                fc_r    <= '0;
                score_r <= '0;
            end else if (game_status && frame_tick_s) begin
                if (fc_r == FC_LAST) begin
                    fc_r <= '0;
                    if (score_r != SCORE_MAX) begin
                        score_r <= score_inc_s;
                    end
                end else begin
                    fc_r <= fc_r + FC_W'(1);
                end
            end
            // BCD digits order like binary, so a plain unsigned compare ranks scores.
            if (stop_s && (score_r > high_r)) begin
                high_r <= score_r;
            end
        end
    end

    // Speed level: hundreds digit, or 15 once thousands is non-zero, then clamped.
    always_comb begin
        if (score_r[15:12] != 4'd0) begin
            level_s = 5'd15;
        end else begin
            level_s = {1'b0, score_r[11:8]};
        end
        speed_sum_s = {1'b0, SPEED_BASE} + level_s;
        if (speed_sum_s > {1'b0, SPEED_MAX}) begin
            speed_next_s = SPEED_MAX;
        end else begin
            speed_next_s = speed_sum_s[SPEED_W-1:0];
        end
    end

    // Registered speed output.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            speed_r <= SPEED_BASE;
        end else begin
            speed_r <= speed_next_s;
        end
    end

    // Digit select and source mux ahead of the decoder.
    always_comb begin
        sel_s   = scan_r[SCAN_BITS-1 -: 2];
        src_s   = show_high ? high_r : score_r;
        digit_s = src_s[3:0];
        case (sel_s)
            2'd0:    digit_s = src_s[3:0];
            2'd1:    digit_s = src_s[7:4];
            2'd2:    digit_s = src_s[11:8];
            2'd3:    digit_s = src_s[15:12];
            default: digit_s = src_s[3:0];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_s),
        .seg (cat_s)
    );

    // Scan counter and registered anode/cathode pair so both switch together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_r    <= '0;
            seg_an_r  <= 4'b1110;
            seg_cat_r <= SEG_0;
        end else begin
            scan_r    <= scan_r + SCAN_BITS'(1);
            seg_an_r  <= ~(4'b0001 << sel_s);
            seg_cat_r <= cat_s;
        end
    end

    assign score_bcd = score_r;
    assign high_bcd  = high_r;
    assign speed     = speed_r;
    assign seg_an    = seg_an_r;
    assign seg_cat   = seg_cat_r;

endmodule

// File: tb/tb_score_board.sv
// Directed bench: one instance at 6 frames/point, one at 1 frame/point for
// reaching large scores quickly; both use a 4-bit scan counter.
module tb_score_board;

    logic        CLK = 1'b0;
    logic        RESET, fresh, game_status, show_high;
    logic [15:0] score6, high6, score1, high1;
    logic [3:0]  speed6, speed1, an6, an1;
    logic [7:0]  cat6, cat1;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    score_board #(.FRAMES_PER_POINT(6), .SCAN_BITS(4)) dut (
        .CLK(CLK), .RESET(RESET), .fresh(fresh), .game_status(game_status),
        .show_high(show_high), .score_bcd(score6), .high_bcd(high6),
        .speed(speed6), .seg_an(an6), .seg_cat(cat6)
    );

    score_board #(.FRAMES_PER_POINT(1), .SCAN_BITS(4)) dut1 (
        .CLK(CLK), .RESET(RESET), .fresh(fresh), .game_status(game_status),
        .show_high(show_high), .score_bcd(score1), .high_bcd(high1),
        .speed(speed1), .seg_an(an1), .seg_cat(cat1)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // n vs falling edges, one every two cycles; starts and ends at a negedge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            fresh = 1'b0;
            @(negedge CLK);
            fresh = 1'b1;
            @(negedge CLK);
        end
    endtask

    // Sync to the start of the units phase, then check all 16 scan cycles.
    task automatic check_scan(input string tag, input bit use1, input logic [31:0] cats);
        int n;
        logic [3:0] exp_an;
        n = 0;
        step();
        while (an6 !== 4'b0111 && n < 40) begin step(); n++; end
        while (an6 !== 4'b1110 && n < 40) begin step(); n++; end
        check_val({tag, "_sync"}, {12'h000, an6}, 16'h000E);
        for (int d = 0; d < 4; d++) begin
            exp_an = 4'b1111 ^ (4'b0001 << d);
            for (int c = 0; c < 4; c++) begin
                check_val({tag, "_an"}, {12'h000, (use1 ? an1 : an6)}, {12'h000, exp_an});
                check_val({tag, "_cat"}, {8'h00, (use1 ? cat1 : cat6)}, {8'h00, cats[8*d +: 8]});
                step();
            end
        end
    endtask

    initial begin
        RESET = 1'b1; fresh = 1'b1; game_status = 1'b0; show_high = 1'b0;
        repeat (3) step();
        check_val("rst_score", score6, 16'h0000);
        check_val("rst_high", high6, 16'h0000);
        check_val("rst_speed", {12'h000, speed6}, 16'h0002);
        check_val("rst_an", {12'h000, an6}, 16'h000E);
        check_val("rst_cat", {8'h00, cat6}, 16'h00C0);
        RESET = 1'b0;
        tick(10);
        check_val("idle_score", score6, 16'h0000);

        // Game 1: 18 edges -> 3 points at 6 frames/point
        game_status = 1'b1; step();
        tick(18);
        check_val("g1_score", score6, 16'h0003);
        check_val("g1_score1", score1, 16'h0018);
        game_status = 1'b0; step();
        tick(5);
        check_val("g1_hold", score6, 16'h0003);
        check_val("g1_high", high6, 16'h0003);

        // Game 2: 42 points
        game_status = 1'b1; step();
        tick(252);
        game_status = 1'b0; step();
        check_val("g2_high", high6, 16'h0042);
        check_val("g2_high1", high1, 16'h0252);
        check_val("g2_speed1", {12'h000, speed1}, 16'h0004);

        // Game 3: 17 points, high holds
        game_status = 1'b1; step();
        check_val("g3_clear", score6, 16'h0000);
        check_val("g3_keep_high", high6, 16'h0042);
        tick(102);
        game_status = 1'b0; step();
        check_val("g3_high", high6, 16'h0042);
        check_val("g3_high1", high1, 16'h0252);

        // Game 4: 0099 -> 0100 speed step, then 0105
        game_status = 1'b1; step();
        tick(594);
        check_val("g4_99", score6, 16'h0099);
        check_val("g4_speed_99", {12'h000, speed6}, 16'h0002);
        tick(5);
        check_val("g4_99b", score6, 16'h0099);
        fresh = 1'b0; step();
        check_val("g4_100", score6, 16'h0100);
        check_val("g4_speed_lag", {12'h000, speed6}, 16'h0002);
        fresh = 1'b1; step();
        check_val("g4_speed_100", {12'h000, speed6}, 16'h0003);
        tick(30);
        check_val("g4_score1", score1, 16'h0630);
        check_val("g4_speed1", {12'h000, speed1}, 16'h0008);
        game_status = 1'b0; step();
        check_val("g4_high", high6, 16'h0105);
        check_val("g4_high1", high1, 16'h0630);

        show_high = 1'b1;
        check_scan("disp_high", 1'b0, {8'hC0, 8'hF9, 8'hC0, 8'h92});
        show_high = 1'b0;

        // Game 5: speed ceiling and saturation on the 1-frame instance
        game_status = 1'b1; step();
        tick(700);
        check_val("g5_700", score1, 16'h0700);
        check_val("g5_speed_700", {12'h000, speed1}, 16'h0009);
        tick(300);
        check_val("g5_1000", score1, 16'h1000);
        check_val("g5_speed_1000", {12'h000, speed1}, 16'h0009);
        tick(234);
        check_val("g5_1234", score1, 16'h1234);
        check_val("g5_205", score6, 16'h0205);
        check_scan("disp_score", 1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h99});
        tick(8764);
        check_val("g5_9998", score1, 16'h9998);
        tick(12);
        check_val("g5_sat", score1, 16'h9999);
        check_val("g5_1668", score6, 16'h1668);
        check_val("g5_speed6", {12'h000, speed6}, 16'h0009);
        game_status = 1'b0; step();
        check_val("g5_high1", high1, 16'h9999);
        check_val("g5_high6", high6, 16'h1668);

        // Start coincident with a frame tick: tick ignored, counter cleared
        game_status = 1'b1; fresh = 1'b0; step();
        check_val("st_clear", score6, 16'h0000);
        check_val("st_clear1", score1, 16'h0000);
        fresh = 1'b1; step();
        tick(5);
        check_val("st_fc5", score6, 16'h0000);
        check_val("st_fc5_1", score1, 16'h0005);
        tick(1);
        check_val("st_fc6", score6, 16'h0001);
        check_val("st_fc6_1", score1, 16'h0006);
        check_val("st_keep_high", high6, 16'h1668);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_board.md
Name: score_board

Overview:
- Downstream consumer of the game-control state (`game_status`) and the VGA frame strobe (`fresh` = vs).
- Keeps a 4-digit BCD running score while a game is in progress and latches a high score when a game ends.
- Produces the `speed` level consumed by the ground and cactus scrollers.
- Drives a time-multiplexed 4-digit seven-segment display.

Parameters:
- FRAMES_PER_POINT, 6, number of frame ticks per score increment (≥1).
- SPEED_BASE, 4'd2, speed at score 0.
- SPEED_MAX, 4'd9, speed ceiling.
- SCAN_BITS, 18, width of the display scan counter; the top 2 bits select the digit.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- fresh  input  1  VGA vertical sync (vs); active-low pulse.
- game_status  input  1  1 = game running, 0 = stopped.
- show_high  input  1  1 = display the high score, 0 = display the current score.
- score_bcd  output  16  current score, 4 BCD digits, [3:0] = units.
- high_bcd  output  16  high score, BCD.
- speed  output  4  scroll speed level.
- seg_an  output  4  digit enables, active low; [0] = units.
- seg_cat  output  8  segments, active low; [7] = dp, [6:0] = g..a.

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - score_bcd = 0, high_bcd = 0, speed = SPEED_BASE.
  - Frame counter = 0, scan counter = 0.
  - seg_an = 4'b1110, seg_cat = 8'hC0 (digit "0", dp off).
  - Edge-detect registers load the current input values, so no false edge appears after reset.
  - RESET overrides every other event.
- Edge detection, all on registered previous values:
  - frame_tick = fresh_prev & ~fresh (vs falling edge).
  - start = ~gs_prev & game_status.
  - stop = gs_prev & ~game_status.
- start:
  - Next cycle: score_bcd = 0, frame counter = 0.
  - A frame_tick in the same cycle is ignored.
  - high_bcd is unchanged.
- Counting, in cycles where game_status=1 and not start:
  - Each frame_tick increments the frame counter.
  - On a tick while the counter == FRAMES_PER_POINT-1, the counter wraps to 0 and score_bcd increments by 1 in BCD. Each digit carries 9→0.
  - Score saturates at 9999: further increments are dropped and the frame counter keeps wrapping.
- While game_status=0: score_bcd and the frame counter hold.
- stop:
  - If score_bcd > high_bcd (4-digit BCD compare, thousands digit first), high_bcd ← score_bcd one cycle later.
  - A simultaneous frame_tick does not increment.
- speed (registered, follows score_bcd with 1-cycle latency):
  - level = 15 if thousands ≠ 0, else the hundreds digit.
  - speed = min(SPEED_BASE + level, SPEED_MAX), computed in 5-bit arithmetic to avoid wrap.
  - On start, speed returns to SPEED_BASE one cycle after the score clears.
- Display:
  - The scan counter free-runs (+1 per CLK), wrapping at 2^SCAN_BITS.
  - sel = scan[SCAN_BITS-1:SCAN_BITS-2].
  - seg_an = ~(4'b0001 << sel).
  - Source value = show_high ? high_bcd : score_bcd; digit = source[4*sel +: 4].
  - seg_an and seg_cat are registered: 1-cycle latency from the scan counter, so they always switch together.
  - No leading-zero blanking.
  - Decode table, active low, {dp,g..a}: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90. Values >9 (unreachable) = FF.
  - dp is always off.
- show_high changes take effect on the next registered display update; there are no glitch constraints.

Decomposition:
- Shared package: segment pattern constants (SEG_0..SEG_9, SEG_BLANK) and BCD digit width/count constants; the cactus/ground scrollers reuse the speed width constant.
- One sub-module: bcd_to_seg (4-bit BCD in, 8-bit active-low pattern out, purely combinational), instantiated once after the digit mux.
- BCD increment and compare stay inline.

Test Plan:
- RESET held 3 cycles, then released with game_status=0 and fresh toggling → score_bcd=0000, high_bcd=0000, speed=2, seg_an=1110, seg_cat=C0; score stays 0 across 10 frames.
- game_status 0→1, then 18 vs falling edges (FRAMES_PER_POINT=6) → score_bcd=0003; frame ticks while game_status=0 change nothing.
- Preload a run to 0099, then 6 more ticks → 0100; one cycle later speed=3. At score 0700, speed=9 (SPEED_MAX). At 1000, speed=9.
- Run to 0042, drop game_status → high_bcd=0042. Restart and stop at 0017 → high stays 0042. Restart and stop at 0105 → high=0105. The restart cleared the score to 0000 without touching high.
- Force score 9998, 12 ticks → 9999 and holds. Assert start coincident with a frame_tick → score=0000, frame counter=0.
- SCAN_BITS=4, score=1234, show_high=0 → seg_an cycles 1110/1101/1011/0111 with seg_cat F9→B0? No: units first → 99 (4), B0 (3), A4 (2), F9 (1). Each step lasts 4 clocks. With show_high=1 and high=0105, digits show 92, C0, F9, C0.
